pipe_stage_reg: RTL

Parametrised pipeline stage register that replaces the hand-written per-field stage registers between CPU pipeline stages, such as ID/EX. It carries one packed payload bus under a valid/ready handshake and supports stage flush (bubble insertion). An optional two-entry skid mode registers the upstream ready path. A saturating stall counter is exported for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Pipeline stage register. It carries one packed payload under a valid/ready
//   handshake and supports a synchronous flush that inserts a bubble.
//   SKID=0: a single head register, with in_ready computed combinationally.
//   SKID=1: head plus skid register. in_ready comes from a flop, gated only by
//           flush.
//   A saturating stall counter counts cycles with out_valid && !out_ready.
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   in_valid/ready  upstream handshake; in_data is the upstream payload
//   flush           kills all held entries; blocks acceptance this cycle
//   out_valid/ready downstream handshake; out_data is the head register
//   occupancy       number of held entries (0..1 or 0..2)
//   stall_cnt       saturating count of downstream stall cycles
module pipe_stage_reg #(
  parameter int               WIDTH     = 64,
  parameter int               SKID      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [WIDTH-1:0] head;
  logic             out_fire;

  assign out_valid = (occupancy != 2'd0);
  assign out_data  = head;
  assign out_fire  = out_valid && out_ready;

  generate
    if (SKID == 0) begin : g_single
      logic hvalid;
      logic in_fire;

      // A full head can accept new data when it drains in the same cycle.
      assign in_ready  = !flush && (!hvalid || out_ready);
      assign in_fire   = in_valid && in_ready;
      assign occupancy = {1'b0, hvalid};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hvalid <= 1'b0;
          head   <= RESET_VAL;
        end else begin
          if (flush)         hvalid <= 1'b0;
          else if (in_fire)  hvalid <= 1'b1;
          else if (out_fire) hvalid <= 1'b0;
          // in_fire is never true during flush, because in_ready is gated by it.
          if (in_fire) head <= in_data;
        end
      end
    end else begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
      } state_t;

      state_t           state, state_nxt;
      logic             ready_q;
      logic [WIDTH-1:0] skid;
      logic             in_fire;
      logic             load_head_in, load_head_skid, load_skid;

      // ready_q holds (state != FULL) as a flop, so the only combinational
      // term on the upstream ready path is the flush gate.
      assign in_ready  = ready_q && !flush;
      assign in_fire   = in_valid && in_ready;
      assign occupancy = state;

      always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
          state_nxt = EMPTY;
        end else begin
          case (state)
            EMPTY: if (in_fire) begin
              load_head_in = 1'b1;
              state_nxt    = ONE;
            end
            ONE: begin
              if (in_fire && out_fire) begin
                load_head_in = 1'b1;
              end else if (in_fire) begin
                load_skid = 1'b1;
                state_nxt = FULL;
              end else if (out_fire) begin
                state_nxt = EMPTY;
              end
            end
            FULL: if (out_fire) begin
              // The skid entry is promoted only after the head has gone out.
              load_head_skid = 1'b1;
              state_nxt      = ONE;
            end
            default: state_nxt = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state   <= EMPTY;
          ready_q <= 1'b1;
          head    <= RESET_VAL;
          skid    <= RESET_VAL;
        end else begin
          state   <= state_nxt;
          ready_q <= (state_nxt != FULL);
          if (load_head_in)        head <= in_data;
          else if (load_head_skid) head <= skid;
          if (load_skid) skid <= in_data;
        end
      end
    end
  endgenerate

  // Stalls are counted even in a flush cycle, before the entries are killed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
